// File: rtl/xtile_loader_burst.sv
// Banked X-tile SRAM plus burst row streamer: reads LANES elements per cycle and hands
// complete rows to the array front-end through a 2-entry row buffer (valid/ready).
//
// state   | meaning
// S_IDLE  | waiting for start; k_count checked here
// S_FETCH | issuing beat reads for the remaining rows of the burst
// S_DRAIN | all reads issued; waiting for the last row handshake
module xtile_loader_burst #(
    parameter int N      = 8,
    parameter int KMAX   = 1024,
    parameter int DATA_W = 32,
    parameter int BYTE_W = DATA_W / 8,
    parameter int LANES  = 2,
    parameter int N_W    = (N > 1) ? $clog2(N) : 1,
    parameter int K_W    = (KMAX > 1) ? $clog2(KMAX) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [K_W-1:0]        k_base,
    input  logic [K_W:0]          k_count,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  row_valid,
    input  logic                  row_ready,
    output logic [K_W-1:0]        row_k,
    output logic                  row_last,
    output logic [N*DATA_W-1:0]   row_data,
    input  logic                  cpu_we,
    input  logic [K_W-1:0]        cpu_k,
    input  logic [N_W-1:0]        cpu_n,
    input  logic [DATA_W-1:0]     cpu_wdata,
    input  logic [BYTE_W-1:0]     cpu_wmask
);
    localparam int BEATS = N / LANES;
    localparam int B_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DEPTH = KMAX * BEATS;
    localparam int A_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int L_W   = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;
    state_t state, state_nxt;

    logic [DATA_W-1:0]   mem [LANES][DEPTH];
    logic [DATA_W-1:0]   rd_q [LANES];
    logic [A_W-1:0]      wr_addr, rd_addr;
    logic [L_W-1:0]      wr_lane;

    logic [K_W-1:0]      cur_k;
    logic [K_W:0]        rows_left;
    logic [B_W-1:0]      beat;
    logic [1:0]          alloc_cnt;
    logic                wr_ptr, rd_ptr;
    logic                rd_en_q, rd_slot_q;
    logic [B_W-1:0]      rd_beat_q;
    logic                slot_full [2];
    logic                slot_last [2];
    logic [K_W-1:0]      slot_k [2];
    logic [N*DATA_W-1:0] slot_data [2];

    logic [K_W+1:0]      end_k;
    logic                legal, issue, last_beat, hs;

    assign wr_addr   = A_W'(32'(cpu_k) * BEATS + 32'(cpu_n) / LANES);
    assign wr_lane   = L_W'(32'(cpu_n) % LANES);
    assign rd_addr   = A_W'(32'(cur_k) * BEATS + 32'(beat));
    assign end_k     = {2'b00, k_base} + {1'b0, k_count};
    assign legal     = (k_count != '0) && (end_k <= (K_W+2)'(KMAX));
    assign last_beat = (beat == B_W'(BEATS - 1));
    // A row claims its slot on its first beat, so only beat 0 waits for a free slot.
    assign issue     = (state == S_FETCH) && !cpu_we && ((beat != '0) || (alloc_cnt != 2'd2));

    assign row_valid = slot_full[rd_ptr];
    assign row_k     = row_valid ? slot_k[rd_ptr] : '0;
    assign row_last  = row_valid ? slot_last[rd_ptr] : 1'b0;
    assign row_data  = row_valid ? slot_data[rd_ptr] : '0;
    assign hs        = row_valid && row_ready;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (cpu_we) begin
            for (int b = 0; b < BYTE_W; b++)
                if (cpu_wmask[b]) mem[wr_lane][wr_addr][b*8 +: 8] <= cpu_wdata[b*8 +: 8];
        end
        if (issue) begin
            for (int l = 0; l < LANES; l++) rd_q[l] <= mem[l][rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start && !abort && legal) state_nxt = S_FETCH;
            S_FETCH: if (abort) state_nxt = S_IDLE;
                     else if (issue && last_beat && rows_left == (K_W+1)'(1)) state_nxt = S_DRAIN;
            S_DRAIN: if (abort || (hs && row_last)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            done         <= 1'b0;
            err          <= 1'b0;
            cur_k        <= '0;
            rows_left    <= '0;
            beat         <= '0;
            alloc_cnt    <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_slot_q    <= 1'b0;
            rd_beat_q    <= '0;
            slot_full[0] <= 1'b0;
            slot_full[1] <= 1'b0;
            slot_last[0] <= 1'b0;
            slot_last[1] <= 1'b0;
            slot_k[0]    <= '0;
            slot_k[1]    <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (state == S_IDLE && start) begin
                if (legal) begin
                    cur_k     <= k_base;
                    rows_left <= k_count;
                    beat      <= '0;
                end else begin
                    err <= 1'b1;
                end
            end
            rd_en_q   <= issue;
            rd_beat_q <= beat;
            rd_slot_q <= wr_ptr;
            if (issue) begin
                if (beat == '0) begin
                    slot_k[wr_ptr]    <= cur_k;
                    slot_last[wr_ptr] <= (rows_left == (K_W+1)'(1));
                end
                if (last_beat) begin
                    beat      <= '0;
                    cur_k     <= cur_k + 1'b1;
                    rows_left <= rows_left - 1'b1;
                    wr_ptr    <= ~wr_ptr;
                end else begin
                    beat <= beat + 1'b1;
                end
            end
            if (rd_en_q) begin
                for (int l = 0; l < LANES; l++)
                    slot_data[rd_slot_q][(int'(rd_beat_q) * LANES + l) * DATA_W +: DATA_W] <= rd_q[l];
                if (rd_beat_q == B_W'(BEATS - 1)) slot_full[rd_slot_q] <= 1'b1;
            end
            if (hs) begin
                slot_full[rd_ptr] <= 1'b0;
                rd_ptr            <= ~rd_ptr;
                if (row_last && state == S_DRAIN) done <= 1'b1;
            end
            alloc_cnt <= alloc_cnt + 2'(issue && beat == '0) - 2'(hs);
        end
    end
endmodule
